// File: rtl/mpu6050_i2c_target_if.sv
// rtl/mpu6050_i2c_target_if.sv - register-write export and busy status of the MPU6050 I2C target
interface mpu6050_i2c_target_if;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport master (output wr_strobe, output wr_addr, output wr_data, output busy);
  modport slave  (input wr_strobe, input wr_addr, input wr_data, input busy);
endinterface

// File: rtl/mpu6050_i2c_target.sv
// rtl/mpu6050_i2c_target.sv - I2C target modelling the MPU6050 register file (128 x 8, auto-increment)
module mpu6050_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter logic [7:0] WHO_AM_I = 8'h68,
  parameter int         FILT_CYC = 3,
  parameter int         HOLD_CYC = 4
) (
  input  logic                        clk50M,
  input  logic                        reset,
  input  logic                        scl,
  inout  wire                         sda,
  mpu6050_i2c_target_if.master        wr_if
);

  localparam int FILT_W = $clog2(FILT_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [6:0] REG_PWR_MGMT_1 = 7'h6B;
  localparam logic [6:0] REG_WHO_AM_I   = 7'h75;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WRITE, S_WR_ACK, S_READ, S_RD_ACK, S_WAIT_STOP
  } state_t;

  function automatic logic [7:0] reg_default(input logic [6:0] a);
    if (a == REG_PWR_MGMT_1) return 8'h40;
    if (a == REG_WHO_AM_I)   return WHO_AM_I;
    return 8'h00;
  endfunction

  // index 0 = scl, index 1 = sda
  logic [1:0]        sync1, sync2, filt, filt_d;
  logic [FILT_W-1:0] fcnt [2];

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {sda, scl};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_W'(FILT_CYC - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FILT_W'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = scl_f & ~filt_d[0];
  assign scl_fall = ~scl_f & filt_d[0];
  assign start_c  = scl_f & filt_d[0] & filt_d[1] & ~sda_f;
  assign stop_c   = scl_f & filt_d[0] & ~filt_d[1] & sda_f;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [6:0]        ptr;
  logic              ack_seen, master_ack, rw;
  logic              sda_oe;
  logic [HOLD_W-1:0] hold_cnt;
  logic              dev_rst_pend;
  logic              strobe_q, busy_q;
  logic [6:0]        waddr_q;
  logic [7:0]        wdata_q;
  logic [127:0]      dirty;
  logic [7:0]        regs [128];

  logic [7:0] byte_in, rd_byte;
  logic       byte_done, reg_we;
  assign byte_in   = {shreg[6:0], sda_f};
  assign byte_done = scl_rise && (bit_cnt == 3'd7) && !start_c && !stop_c;
  assign reg_we    = byte_done && (state == S_WRITE) && (ptr != REG_WHO_AM_I);
  // Registers never written since reset read their default; clearing dirty is a full-file reset.
  assign rd_byte   = dirty[ptr] ? regs[ptr] : reg_default(ptr);

  always_ff @(posedge clk50M) begin
    if (reg_we) regs[ptr] <= byte_in;
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      ptr          <= 7'h00;
      ack_seen     <= 1'b0;
      master_ack   <= 1'b0;
      rw           <= 1'b0;
      sda_oe       <= 1'b0;
      hold_cnt     <= '0;
      dev_rst_pend <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      waddr_q      <= 7'h00;
      wdata_q      <= 8'h00;
      dirty        <= '0;
    end else begin
      strobe_q     <= 1'b0;
      dev_rst_pend <= 1'b0;
      if (reg_we) dirty[ptr] <= 1'b1;
      if (dev_rst_pend) dirty <= '0;

      if (scl_fall)
        hold_cnt <= HOLD_W'(HOLD_CYC);
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - HOLD_W'(1);

      if (start_c) begin
        state    <= S_ADDR;
        bit_cnt  <= 3'd0;
        ack_seen <= 1'b0;
        sda_oe   <= 1'b0;
      end else if (stop_c) begin
        state    <= S_IDLE;
        busy_q   <= 1'b0;
        ack_seen <= 1'b0;
        sda_oe   <= 1'b0;
      end else begin
        // sda only moves once scl has been low for HOLD_CYC cycles
        if (hold_cnt == HOLD_W'(1)) begin
          case (state)
            S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: sda_oe <= 1'b1;
            S_READ:                          sda_oe <= ~shreg[7];
            default:                         sda_oe <= 1'b0;
          endcase
        end

        case (state)
          S_ADDR, S_PTR, S_WRITE: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              ack_seen <= 1'b0;
              if (state == S_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state  <= S_ADDR_ACK;
                  rw     <= byte_in[0];
                  busy_q <= 1'b1;
                end else begin
                  state  <= S_WAIT_STOP;
                  busy_q <= 1'b0;
                end
              end else if (state == S_PTR) begin
                state <= S_PTR_ACK;
                ptr   <= byte_in[6:0];
              end else begin
                state    <= S_WR_ACK;
                strobe_q <= 1'b1;
                waddr_q  <= ptr;
                wdata_q  <= byte_in;
                ptr      <= ptr + 7'd1;
                if (ptr == REG_PWR_MGMT_1 && byte_in[7]) dev_rst_pend <= 1'b1;
              end
            end
          end

          S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
            if (scl_rise) begin
              ack_seen <= 1'b1;
            end else if (scl_fall && ack_seen) begin
              ack_seen <= 1'b0;
              bit_cnt  <= 3'd0;
              if (state == S_ADDR_ACK && rw) begin
                state <= S_READ;
                shreg <= rd_byte;
              end else if (state == S_ADDR_ACK) begin
                state <= S_PTR;
              end else begin
                state <= S_WRITE;
              end
            end
          end

          S_READ: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state    <= S_RD_ACK;
                ack_seen <= 1'b0;
                ptr      <= ptr + 7'd1;
              end
            end
          end

          S_RD_ACK: begin
            if (scl_rise) begin
              ack_seen   <= 1'b1;
              master_ack <= ~sda_f;
            end else if (scl_fall && ack_seen) begin
              ack_seen <= 1'b0;
              bit_cnt  <= 3'd0;
              if (master_ack) begin
                state <= S_READ;
                shreg <= rd_byte;
              end else begin
                state  <= S_WAIT_STOP;
                busy_q <= 1'b0;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign sda             = sda_oe ? 1'b0 : 1'bz;
  assign wr_if.wr_strobe = strobe_q;
  assign wr_if.wr_addr   = waddr_q;
  assign wr_if.wr_data   = wdata_q;
  assign wr_if.busy      = busy_q;

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
// tb/tb_mpu6050_i2c_target.sv - bit-banged I2C master driving the MPU6050 target, scoreboard checked
module tb_mpu6050_i2c_target;
  localparam int Q = 16;

  logic clk50M    = 1'b0;
  logic reset     = 1'b1;
  logic m_scl     = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  mpu6050_i2c_target_if wr_if ();

  mpu6050_i2c_target dut (
    .clk50M (clk50M),
    .reset  (reset),
    .scl    (m_scl),
    .sda    (sda),
    .wr_if  (wr_if)
  );

  always #10 clk50M = ~clk50M;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [14:0] exp_wr_q [$];
  logic [8:0]  exp_bus_q [$];
  logic        obs_valid = 1'b0;
  logic [8:0]  obs_val   = 9'h000;
  logic [14:0] mon_wr_e;
  logic [8:0]  mon_bus_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk50M);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_q();
    m_scl     = 1'b1; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl     = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl     = 1'b1; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; wait_q();
    m_scl     = 1'b1; wait_q(); wait_q();
    m_scl     = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    m_scl     = 1'b1; wait_q();
    b         = sda;  wait_q();
    m_scl     = 1'b0; wait_q();
  endtask

  task automatic report(input logic [8:0] v);
    obs_val   = v;
    obs_valid = 1'b1;
    @(negedge clk50M);
    obs_valid = 1'b0;
  endtask

  // bit 8 of a bus entry: 0 = ack bit seen by master, 1 = data byte read by master
  task automatic send_byte(input logic [7:0] d, input logic exp_nack);
    logic a;
    exp_bus_q.push_back({1'b0, 7'd0, exp_nack});
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    report({1'b0, 7'd0, a});
  endtask

  task automatic recv_byte(input logic [7:0] expv, input logic nack);
    logic [7:0] d;
    logic       b;
    exp_bus_q.push_back({1'b1, expv});
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    report({1'b1, d});
    put_bit(nack);
  endtask

  task automatic write_regs(input logic [6:0] p, input logic [7:0] d0, input logic [7:0] d1, input int n);
    bus_start();
    send_byte(8'hD0, 1'b0);
    check("busy_set", wr_if.busy, 1);
    send_byte({1'b0, p}, 1'b0);
    exp_wr_q.push_back({p, d0});
    send_byte(d0, 1'b0);
    if (n > 1) begin
      exp_wr_q.push_back({p + 7'd1, d1});
      send_byte(d1, 1'b0);
    end
    bus_stop();
    check("busy_clr_after_stop", wr_if.busy, 0);
    check("sda_idle_after_write", sda, 1);
  endtask

  task automatic read_regs(input logic [6:0] p, input int n, input logic [7:0] e0, input logic [7:0] e1);
    bus_start();
    send_byte(8'hD0, 1'b0);
    send_byte({1'b0, p}, 1'b0);
    bus_start();
    send_byte(8'hD1, 1'b0);
    recv_byte(e0, n == 1);
    if (n > 1) recv_byte(e1, 1'b1);
    check("sda_released_after_nack", sda, 1);
    bus_stop();
    check("sda_idle_after_read", sda, 1);
  endtask

  always @(negedge clk50M) begin
    #1;
    if (!reset) begin
      if (wr_if.wr_strobe) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wr_if.wr_addr, wr_if.wr_data);
        end else begin
          mon_wr_e = exp_wr_q.pop_front();
          check("wr_export", {wr_if.wr_addr, wr_if.wr_data}, mon_wr_e);
        end
      end
      if (obs_valid) begin
        if (exp_bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_unexpected: got 0x%0h, expected nothing", obs_val);
        end else begin
          mon_bus_e = exp_bus_q.pop_front();
          check(mon_bus_e[8] ? "bus_read_byte" : "bus_ack_bit", obs_val, mon_bus_e);
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk50M);
    $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
    $fatal(1);
  end

  initial begin
    logic b;
    repeat (5) @(negedge clk50M);
    reset = 1'b0;
    wait_q();
    check("rst_busy", wr_if.busy, 0);
    check("rst_wr_strobe", wr_if.wr_strobe, 0);
    check("rst_wr_addr", wr_if.wr_addr, 0);
    check("rst_wr_data", wr_if.wr_data, 0);
    check("rst_sda", sda, 1);

    // WHO_AM_I via pointer write + repeated start
    read_regs(7'h75, 1, 8'h68, 8'h00);

    // burst write with auto-increment, then read-back
    write_regs(7'h1B, 8'h18, 8'h00, 2);
    read_regs(7'h1B, 2, 8'h18, 8'h00);

    // pointer wrap 0x7F -> 0x00 on write and read
    write_regs(7'h7F, 8'hAA, 8'h55, 2);
    read_regs(7'h7F, 2, 8'hAA, 8'h55);

    // foreign address 0x69: no ACK, no busy, no write
    bus_start();
    send_byte(8'hD2, 1'b1);
    check("mismatch_busy", wr_if.busy, 0);
    send_byte(8'h1B, 1'b1);
    bus_stop();
    read_regs(7'h1B, 1, 8'h18, 8'h00);

    // read-only WHO_AM_I and DEVICE_RESET
    write_regs(7'h1B, 8'h18, 8'h00, 1);
    write_regs(7'h75, 8'h12, 8'h00, 1);
    read_regs(7'h75, 1, 8'h68, 8'h00);
    write_regs(7'h6B, 8'h80, 8'h00, 1);
    read_regs(7'h6B, 1, 8'h40, 8'h00);
    read_regs(7'h1B, 1, 8'h00, 8'h00);
    read_regs(7'h75, 1, 8'h68, 8'h00);

    // reset during the 4th bit of a read byte (0x07: top bits driven low)
    write_regs(7'h1A, 8'h07, 8'h00, 1);
    bus_start();
    send_byte(8'hD0, 1'b0);
    send_byte(8'h1A, 1'b0);
    bus_start();
    send_byte(8'hD1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      get_bit(b);
      check("partial_read_bit", b, 0);
    end
    m_sda_low = 1'b0; wait_q();
    m_scl     = 1'b1; wait_q();
    check("pre_reset_sda_driven", sda, 0);
    check("pre_reset_busy", wr_if.busy, 1);
    reset = 1'b1;
    #1;
    check("reset_sda_released", sda, 1);
    check("reset_busy", wr_if.busy, 0);
    check("reset_wr_addr", wr_if.wr_addr, 0);
    check("reset_wr_data", wr_if.wr_data, 0);
    repeat (5) @(negedge clk50M);
    reset = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
    read_regs(7'h1A, 1, 8'h00, 8'h00);

    repeat (20) @(negedge clk50M);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("bus_queue_drained", exp_bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
